matmul_nxn_stream: RTL
======================

# matmul_nxn_stream

Parametrised N×N matrix multiplier: C = A × B. Matrices A and B are loaded over a valid/ready input stream. Products and accumulation run through a two-stage pipelined MAC at one multiply per cycle. C is returned over a valid/ready output stream with last-beat marking. It is the general-size, handshaked, signed-capable successor to the fixed 3×3 pipelined multiplier, and sits between the host/UART data path and the display logic.

## Interface
- DATA_WIDTH, 8: element width of A and B.
- N, 3: matrix dimension (N ≥ 2).
- ACC_WIDTH, 18: width of C elements; legal range ≥ 2·DATA_WIDTH; a full-precision result needs ≥ 2·DATA_WIDTH+ceil(log2 N).
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and result.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input word.
- in_data  in  DATA_WIDTH  operand word: A row-major, then B row-major.
- out_valid  out  1  C element valid.
- out_ready  in  1  consumer accepts C element.
- out_data  out  ACC_WIDTH  C element, row-major order.
- out_last  out  1  high with the final element C[N-1][N-1].
- busy  out  1  high in COMPUTE and OUTPUT.
- done  out  1  one-cycle pulse in the cycle after the final output handshake.

## Operation
- States: LOAD_A → LOAD_B → COMPUTE → OUTPUT → LOAD_A.
- LOAD_A:
  - in_ready=1.
  - Each transfer (in_valid&&in_ready) writes A[idx], then increments idx.
  - After the N²-th transfer, go to LOAD_B with idx=0.
- LOAD_B:
  - Same as LOAD_A, writing B.
  - After the N²-th transfer, go to COMPUTE.
  - in_valid while in_ready=0 is ignored.
- COMPUTE:
  - Counters i, j, k iterate with k innermost, then j, then i.
  - Stage 1 registers prod = A[i][k]·B[k][j] at full 2·DATA_WIDTH precision, signed or unsigned per SIGNED.
  - Stage 2 computes acc = (k==0 ? prod : acc+prod), sign- or zero-extended to ACC_WIDTH.
  - On k==N-1, stage 2 writes C[i][j]. The registered k/i/j travel with the product down the pipe.
  - Arithmetic wraps modulo 2^ACC_WIDTH; there is no saturation and no overflow flag.
  - After the last product drains, go to OUTPUT.
- OUTPUT:
  - out_valid=1; out_data=C[oidx]; out_last=(oidx==N²-1).
  - On out_valid&&out_ready, oidx increments.
  - On the final handshake, go to LOAD_A. A, B and C contents are retained but overwritten by the next job.
- in_ready=0 in COMPUTE and OUTPUT. out_valid=0 outside OUTPUT.

## Timing
- Reset values: in_ready=1 (state LOAD_A), out_valid=0, out_data=0, out_last=0, busy=0, done=0. All indices, counters and C are cleared to 0.
- Reset asserted in any state, including mid-load, mid-compute or mid-output, aborts the job. Outputs take reset values on the next edge; partial loads are discarded.
- Let the final B transfer occur in cycle t. Then:
  - COMPUTE occupies cycles t+1 … t+N³+2: N³ issue cycles plus 2 drain cycles.
  - out_valid first rises in cycle t+N³+3; for N=3 that is t+30.
- The output stream holds data:
  - out_data and out_last are stable while out_valid && !out_ready.
  - One beat transfers per cycle while out_ready is held high.
- Stream timing:
  - With out_ready held high, N² beats occur in consecutive cycles.
  - done pulses in the cycle after the last beat, when in_ready=1 again.
- Input accepts one word per cycle with no bubble between the A and B phases.
- busy is high exactly while the state is COMPUTE or OUTPUT.

## Test plan
- Basic, N=3, unsigned:
  - Stimulus: A=1..9 and B=9..1, streamed back-to-back; out_ready held high.
  - Required: out_data=30,24,18,84,69,54,138,114,90; out_last on the 9th beat; first out_valid exactly 30 cycles after the final B transfer; done one cycle after beat 9.
- Max operands:
  - Stimulus: all A and B elements = 255, ACC_WIDTH=18.
  - Required: every C element = 195075 (0x2FA03).
  - Stimulus: same with ACC_WIDTH=16.
  - Required: every element = 64003 (wrap).
- Signed, SIGNED=1:
  - Stimulus: A all 0xFF (−1), B = 2·I.
  - Required: every C element = −2 (out_data 0x3FFFE at ACC_WIDTH=18).
- Backpressure:
  - Stimulus: random in_valid gaps; out_ready toggled 1/0 pseudo-randomly.
  - Required: results identical to the basic case; out_data/out_last stable while stalled; in_valid during COMPUTE/OUTPUT is never accepted.
- Reset mid-job:
  - Stimulus: assert rst for one cycle during COMPUTE, then run the basic job again.
  - Required: outputs at reset values the next cycle; second job produces the correct C.
- Parameter sweep:
  - Stimulus: N=2 and N=4 with random operands.
  - Required: output matches a reference model; COMPUTE length N³+2.

Source files
------------

// File: rtl/matmul_nxn_stream.sv
// N x N matrix multiplier C = A x B: A and B are streamed in, a two-stage MAC issues one
// product per cycle, and C is streamed out row-major with last-beat marking.
module matmul_nxn_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N          = 3,
  parameter int unsigned ACC_WIDTH  = 18,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NN    = N * N;
  localparam int unsigned NCUBE = N * N * N;
  localparam int unsigned IdxW  = $clog2(NN);
  localparam int unsigned CW    = $clog2(N);
  localparam int unsigned CntW  = $clog2(NCUBE + 2);
  localparam int unsigned PW    = 2 * DATA_WIDTH;

  // Upper-bit masks used to sign-extend operands and products when SIGNED is set.
  localparam logic [PW-1:0]        OpHi  = ~PW'({DATA_WIDTH{1'b1}});
  localparam logic [ACC_WIDTH-1:0] AccHi = ~ACC_WIDTH'({PW{1'b1}});

  typedef enum logic [1:0] {StLoadA, StLoadB, StCompute, StOutput} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     oidx_q, oidx_d;
  logic [CW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                s1_valid_q;
  logic [CW-1:0]       s1_i_q, s1_j_q, s1_k_q;
  logic [PW-1:0]       prod_q, prod_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                done_q;

  logic [DATA_WIDTH-1:0] a_mem [NN];
  logic [DATA_WIDTH-1:0] b_mem [NN];
  logic [ACC_WIDTH-1:0]  c_mem [NN];

  logic                 in_fire, out_fire, idx_last, oidx_last, issue, compute_end;
  logic [IdxW-1:0]      a_addr, b_addr, c_addr;
  logic [PW-1:0]        a_ext, b_ext;
  logic [ACC_WIDTH-1:0] prod_ext;

  assign in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
  assign out_valid = (state_q == StOutput);
  assign busy      = (state_q == StCompute) || (state_q == StOutput);
  assign done      = done_q;
  assign out_data  = out_valid ? c_mem[oidx_q] : '0;
  assign out_last  = out_valid && oidx_last;

  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign idx_last    = (idx_q == IdxW'(NN - 1));
  assign oidx_last   = (oidx_q == IdxW'(NN - 1));
  assign issue       = (state_q == StCompute) && (cnt_q < CntW'(NCUBE));
  assign compute_end = (state_q == StCompute) && (cnt_q == CntW'(NCUBE + 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoadA:   if (in_fire && idx_last) state_d = StLoadB;
      StLoadB:   if (in_fire && idx_last) state_d = StCompute;
      StCompute: if (compute_end) state_d = StOutput;
      StOutput:  if (out_fire && oidx_last) state_d = StLoadA;
      default:   state_d = StLoadA;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    oidx_d = oidx_q;
    cnt_d  = '0;
    i_d    = i_q;
    j_d    = j_q;
    k_d    = k_q;
    if (in_fire) idx_d = idx_last ? '0 : idx_q + 1'b1;
    if (out_fire) oidx_d = oidx_last ? '0 : oidx_q + 1'b1;
    if (state_q == StCompute && !compute_end) cnt_d = cnt_q + 1'b1;
    // k innermost, then j, then i; all wrap back to zero after the final product
    if (issue) begin
      if (k_q == CW'(N - 1)) begin
        k_d = '0;
        if (j_q == CW'(N - 1)) begin
          j_d = '0;
          i_d = (i_q == CW'(N - 1)) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_comb begin
    a_addr   = IdxW'(i_q * N + k_q);
    b_addr   = IdxW'(k_q * N + j_q);
    c_addr   = IdxW'(s1_i_q * N + s1_j_q);
    a_ext    = PW'(a_mem[a_addr]) | ((SIGNED && a_mem[a_addr][DATA_WIDTH-1]) ? OpHi : '0);
    b_ext    = PW'(b_mem[b_addr]) | ((SIGNED && b_mem[b_addr][DATA_WIDTH-1]) ? OpHi : '0);
    prod_d   = a_ext * b_ext;
    prod_ext = ACC_WIDTH'(prod_q) | ((SIGNED && prod_q[PW-1]) ? AccHi : '0);
    acc_d    = (s1_k_q == '0) ? prod_ext : acc_q + prod_ext;
  end

  // Operand storage needs no reset: every job fully rewrites A and B before use.
  always_ff @(posedge clk) begin
    if (in_fire && state_q == StLoadA) a_mem[idx_q] <= in_data;
    if (in_fire && state_q == StLoadB) b_mem[idx_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoadA;
      idx_q      <= '0;
      oidx_q     <= '0;
      cnt_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_i_q     <= '0;
      s1_j_q     <= '0;
      s1_k_q     <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
      for (int n = 0; n < NN; n++) c_mem[n] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      oidx_q     <= oidx_d;
      cnt_q      <= cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      s1_valid_q <= issue;
      s1_i_q     <= i_q;
      s1_j_q     <= j_q;
      s1_k_q     <= k_q;
      prod_q     <= prod_d;
      done_q     <= out_fire && oidx_last;
      if (s1_valid_q) begin
        acc_q <= acc_d;
        if (s1_k_q == CW'(N - 1)) c_mem[c_addr] <= acc_d;
      end
    end
  end

endmodule
